cog_ram_dp: RTL and testbench
=============================

Name: cog_ram_dp

Overview:
Parametrised dual-port successor to the single-port cog register RAM.
- Port A: read/write with byte-lane enables. Port B: read-only, for debug/trace taps and a future shadow-fetch path.
- Built-in clear sequencer zero-fills the array after reset, so cog memory starts deterministic without loader involvement.
- Sits between cog core and hub loader. Sized and configured per cog variant through parameters.

Parameters:
DW, 32, data width in bits; must be a multiple of 8.
AW, 9, address width; depth = 2**AW words.
CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset release; 0 = skip straight to READY.
B_BYPASS, 0, 1 = port B returns port A write data on same-address collision; 0 = returns old data.

Ports:
clk  input  1  clock; all logic on rising edge
nres  input  1  asynchronous active-low reset
ena_a  input  1  port A enable
w_a  input  1  port A write strobe; qualified by ena_a
be_a  input  DW/8  port A byte-lane write enables; bit i covers d_a[8i+7:8i]
a_a  input  AW  port A address
d_a  input  DW  port A write data
q_a  output  DW  port A registered read data
ena_b  input  1  port B enable
a_b  input  AW  port B address
q_b  output  DW  port B registered read data
busy  output  1  high while clear sweep active; both ports ignored

Behaviour:
- Reset: nres low asynchronously forces q_a=0, q_b=0, clear counter=0.
  - busy=1 if CLEAR_ON_RESET=1, else busy=0.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: write 0 to all lanes at address = counter; counter increments each cycle. When counter == 2**AW-1, the write completes that cycle and the next state is READY.
  - READY: normal operation; terminal until next reset.
  - CLEAR lasts exactly 2**AW cycles after nres rises.
- busy = (state == CLEAR), registered. First usable access is the cycle after busy falls.
- nres asserted mid-sweep: sweep restarts from address 0 on release; no partial-state carry-over.
- During CLEAR, ena_a/w_a/ena_b are ignored: no user write, q_a and q_b hold 0.
- Port A, READY:
  - ena_a=1: q_a <= mem[a_a] on the next edge (1-cycle latency, read-first).
  - ena_a=1 and w_a=1: for each i with be_a[i]=1, mem[a_a] lane i <= d_a lane i. Lanes with be_a[i]=0 are unchanged.
  - Same-cycle read returns pre-write contents (old data).
  - w_a=1 with be_a all zero: no write, read still occurs.
- ena_a=0: q_a holds its previous value; no write even if w_a=1.
- Port B, READY:
  - ena_b=1: q_b <= mem[a_b], 1-cycle latency.
  - ena_b=0: q_b holds.
- Collision (ena_a & w_a & ena_b & a_a==a_b, READY):
  - B_BYPASS=0: q_b = old word.
  - B_BYPASS=1: q_b = merged word (new lanes where be_a set, old lanes elsewhere).
- Address wrap: addresses are AW bits; no out-of-range case exists.
- No X on q_a/q_b after reset with CLEAR_ON_RESET=1. With CLEAR_ON_RESET=0, reads of unwritten words are undefined.

Test Plan:
1. Reset sweep, AW=4 (16 words), CLEAR_ON_RESET=1: release nres -> busy high exactly 16 cycles. Then port A reads of all 16 addresses -> 0x00000000 each.
2. Byte-enable write: write 0xAABBCCDD be=4'b1111 @0x005, then 0x11223344 be=4'b0101 @0x005, then read -> q_a=0xAA22CC44 one cycle after read issue.
3. Read-first: mem[0x010]=0x12345678; ena_a=1 w_a=1 d_a=0xCAFEF00D @0x010 -> q_a=0x12345678 next cycle. Following read -> 0xCAFEF00D.
4. Collision: mem[0x020]=0, write 0xFFFFFFFF be=4'b0011 @0x020 with port B reading 0x020 -> q_b=0 (B_BYPASS=0) or 0x0000FFFF (B_BYPASS=1).
5. Hold/ignore: ena_a=0 w_a=1 d_a=0xDEADBEEF @0x030 -> mem[0x030] unchanged, q_a holds prior value. Same check for ena_b=0 on q_b.
6. Reset mid-sweep, AW=4: assert nres at sweep cycle 7, release -> busy high a full 16 cycles again. Accesses with ena_a=1 w_a=1 during busy leave contents 0.

Source files
------------

// File: rtl/cog_ram_dp.sv
// ---------------------------------------------------------------------------
// cog_ram_dp: dual-port cog register RAM with built-in zero-fill sequencer.
//
// Port A is read/write with byte-lane enables and read-first behaviour.
// Port B is read-only (debug/trace taps, shadow fetch). Both ports have a
// one-cycle registered read latency. After reset release an optional clear
// sweep writes zero to every word, one word per cycle, while busy is high.
// Both ports are ignored during the sweep.
//
// Parameters:
//   DW             data width in bits (multiple of 8)
//   AW             address width, depth = 2**AW words
//   CLEAR_ON_RESET 1 = zero-fill after reset, 0 = ready immediately
//   B_BYPASS       1 = port B sees port A's merged write data on a
//                  same-address collision, 0 = port B sees the old word
//
// Ports:
//   clk    rising-edge clock
//   nres   asynchronous active-low reset
//   ena_a  port A enable
//   w_a    port A write strobe (qualified by ena_a)
//   be_a   port A byte-lane write enables, bit i covers d_a[8i+7:8i]
//   a_a    port A address
//   d_a    port A write data
//   q_a    port A registered read data
//   ena_b  port B enable
//   a_b    port B address
//   q_b    port B registered read data
//   busy   high while the clear sweep runs
// ---------------------------------------------------------------------------
module cog_ram_dp #(
  parameter int unsigned DW             = 32,
  parameter int unsigned AW             = 9,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter bit          B_BYPASS       = 1'b0
) (
  input  logic            clk,
  input  logic            nres,
  input  logic            ena_a,
  input  logic            w_a,
  input  logic [DW/8-1:0] be_a,
  input  logic [AW-1:0]   a_a,
  input  logic [DW-1:0]   d_a,
  output logic [DW-1:0]   q_a,
  input  logic            ena_b,
  input  logic [AW-1:0]   a_b,
  output logic [DW-1:0]   q_b,
  output logic            busy
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } state_e;

  state_e          state;
  logic [AW-1:0]   clr_cnt;
  logic [DW-1:0]   mem [DEPTH];

  logic            wr_a;
  logic            collide;
  logic [DW-1:0]   merged;

  // User write only once the sweep is done.
  assign wr_a    = (state == StReady) && ena_a && w_a;
  assign collide = wr_a && (a_a == a_b);

  // Word as it will look after this cycle's port A write (bypass source).
  always_comb begin
    merged = mem[a_a];
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) begin
        merged[8*i +: 8] = d_a[8*i +: 8];
      end
    end
  end

  // Storage: no reset; the sweep provides the deterministic start state.
  always_ff @(posedge clk) begin
    if (state == StClear) begin
      mem[clr_cnt] <= '0;
    end else if (wr_a) begin
      for (int i = 0; i < NB; i++) begin
        if (be_a[i]) begin
          mem[a_a][8*i +: 8] <= d_a[8*i +: 8];
        end
      end
    end
  end

  // Sequencer plus registered read ports.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state   <= CLEAR_ON_RESET ? StClear : StReady;
      busy    <= CLEAR_ON_RESET;
      clr_cnt <= '0;
      q_a     <= '0;
      q_b     <= '0;
    end else begin
      unique case (state)
        StClear: begin
          clr_cnt <= clr_cnt + 1'b1;
          // Last word is written this cycle; ports usable from the next one.
          if (clr_cnt == {AW{1'b1}}) begin
            state <= StReady;
            busy  <= 1'b0;
          end
        end
        StReady: begin
          if (ena_a) begin
            q_a <= mem[a_a];
          end
          if (ena_b) begin
            q_b <= (B_BYPASS && collide) ? merged : mem[a_b];
          end
        end
        default: begin
          state <= StReady;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cog_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_cog_ram_dp: directed bench for cog_ram_dp.
// Four instances share one stimulus bus:
//   u_a  AW=8, B_BYPASS=0       u_b  AW=8, B_BYPASS=1
//   u_s  AW=4, B_BYPASS=0       u_n  AW=4, CLEAR_ON_RESET=0
// The AW=4 instances see the low four address bits.
// ---------------------------------------------------------------------------
module tb_cog_ram_dp;

  logic        clk = 1'b0;
  logic        nres;
  logic        ena_a, w_a, ena_b;
  logic [3:0]  be_a;
  logic [7:0]  a_a, a_b;
  logic [31:0] d_a;

  logic [31:0] qa_a, qb_a, qa_b, qb_b, qa_s, qb_s, qa_n, qb_n;
  logic        busy_a, busy_b, busy_s, busy_n;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cog_ram_dp #(.DW(32), .AW(8), .CLEAR_ON_RESET(1'b1), .B_BYPASS(1'b0)) u_a (
    .clk(clk), .nres(nres), .ena_a(ena_a), .w_a(w_a), .be_a(be_a), .a_a(a_a), .d_a(d_a),
    .q_a(qa_a), .ena_b(ena_b), .a_b(a_b), .q_b(qb_a), .busy(busy_a)
  );

  cog_ram_dp #(.DW(32), .AW(8), .CLEAR_ON_RESET(1'b1), .B_BYPASS(1'b1)) u_b (
    .clk(clk), .nres(nres), .ena_a(ena_a), .w_a(w_a), .be_a(be_a), .a_a(a_a), .d_a(d_a),
    .q_a(qa_b), .ena_b(ena_b), .a_b(a_b), .q_b(qb_b), .busy(busy_b)
  );

  cog_ram_dp #(.DW(32), .AW(4), .CLEAR_ON_RESET(1'b1), .B_BYPASS(1'b0)) u_s (
    .clk(clk), .nres(nres), .ena_a(ena_a), .w_a(w_a), .be_a(be_a), .a_a(a_a[3:0]),
    .d_a(d_a), .q_a(qa_s), .ena_b(ena_b), .a_b(a_b[3:0]), .q_b(qb_s), .busy(busy_s)
  );

  cog_ram_dp #(.DW(32), .AW(4), .CLEAR_ON_RESET(1'b0), .B_BYPASS(1'b0)) u_n (
    .clk(clk), .nres(nres), .ena_a(ena_a), .w_a(w_a), .be_a(be_a), .a_a(a_a[3:0]),
    .d_a(d_a), .q_a(qa_n), .ena_b(ena_b), .a_b(a_b[3:0]), .q_b(qb_n), .busy(busy_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena_a = 1'b0; w_a = 1'b0; be_a = 4'h0; a_a = 8'h00; d_a = 32'h0;
    ena_b = 1'b0; a_b = 8'h00;
  endtask

  // Counts cycles from reset release until busy drops on the small and big
  // instances; optionally drives writes during the first 16 cycles.
  task automatic sweep_len(input bit do_writes, output int ks, output int kb);
    ks = 0;
    kb = 0;
    for (int k = 1; k <= 300; k++) begin
      ena_a = do_writes;
      w_a   = do_writes && (k <= 16);
      be_a  = 4'hF;
      d_a   = 32'hFFFF_FFFF;
      a_a   = 8'(k - 1);
      ena_b = do_writes;
      a_b   = 8'(k - 1);
      tick();
      if (do_writes && k == 8) begin
        vecs++;
        if (qa_s !== 32'h0 || qb_s !== 32'h0 || qa_a !== 32'h0) begin
          errs++;
          $display("FAIL busy_q_hold got qa_s=%h qb_s=%h qa_a=%h want 0", qa_s, qb_s, qa_a);
        end
      end
      if (ks == 0 && busy_s === 1'b0) ks = k;
      if (kb == 0 && busy_a === 1'b0) kb = k;
      if (ks != 0 && kb != 0) break;
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    nres = 1'b0;
    tick();
    tick();
    vecs++;
    if (qa_a !== 32'h0 || qb_a !== 32'h0) begin
      errs++;
      $display("FAIL reset_q got q_a=%h q_b=%h want 0", qa_a, qb_a);
    end
    vecs++;
    if (busy_a !== 1'b1 || busy_s !== 1'b1) begin
      errs++;
      $display("FAIL reset_busy got %b/%b want 1/1", busy_a, busy_s);
    end
    vecs++;
    if (busy_n !== 1'b0) begin
      errs++;
      $display("FAIL reset_busy_noclear got %b want 0", busy_n);
    end
  endtask

  task automatic test_sweep();
    int ks, kb;
    nres = 1'b1;
    sweep_len(1'b0, ks, kb);
    vecs++;
    if (ks != 16) begin
      errs++;
      $display("FAIL sweep_len_small got %0d want 16", ks);
    end
    vecs++;
    if (kb != 256) begin
      errs++;
      $display("FAIL sweep_len_big got %0d want 256", kb);
    end
    vecs++;
    if (busy_n !== 1'b0) begin
      errs++;
      $display("FAIL sweep_busy_noclear got %b want 0", busy_n);
    end
    ena_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_a = 8'(i);
      tick();
      vecs++;
      if (qa_s !== 32'h0) begin
        errs++;
        $display("FAIL sweep_read_small[%0d] got %h want 00000000", i, qa_s);
      end
    end
    a_a = 8'hFF;
    tick();
    vecs++;
    if (qa_a !== 32'h0) begin
      errs++;
      $display("FAIL sweep_read_big_ff got %h want 00000000", qa_a);
    end
    idle();
  endtask

  task automatic test_byte_enable();
    ena_a = 1'b1; w_a = 1'b1; a_a = 8'h05;
    d_a = 32'hAABB_CCDD; be_a = 4'b1111;
    tick();
    d_a = 32'h1122_3344; be_a = 4'b0101;
    tick();
    w_a = 1'b0;
    tick();
    vecs++;
    if (qa_a !== 32'hAA22_CC44 || qa_b !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL byte_enable got %h/%h want aa22cc44", qa_a, qa_b);
    end
    vecs++;
    if (qa_n !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL byte_enable_noclear got %h want aa22cc44", qa_n);
    end
    idle();
  endtask

  task automatic test_read_first();
    ena_a = 1'b1; w_a = 1'b1; a_a = 8'h10; be_a = 4'hF;
    d_a = 32'h1234_5678;
    tick();
    d_a = 32'hCAFE_F00D;
    tick();
    vecs++;
    if (qa_a !== 32'h1234_5678) begin
      errs++;
      $display("FAIL read_first_old got %h want 12345678", qa_a);
    end
    w_a = 1'b0;
    tick();
    vecs++;
    if (qa_a !== 32'hCAFE_F00D) begin
      errs++;
      $display("FAIL read_first_new got %h want cafef00d", qa_a);
    end
    idle();
  endtask

  task automatic test_collision();
    ena_a = 1'b1; w_a = 1'b1; a_a = 8'h20; be_a = 4'b0011; d_a = 32'hFFFF_FFFF;
    ena_b = 1'b1; a_b = 8'h20;
    tick();
    vecs++;
    if (qb_a !== 32'h0) begin
      errs++;
      $display("FAIL collide_nobypass got %h want 00000000", qb_a);
    end
    vecs++;
    if (qb_b !== 32'h0000_FFFF) begin
      errs++;
      $display("FAIL collide_bypass got %h want 0000ffff", qb_b);
    end
    vecs++;
    if (qa_a !== 32'h0) begin
      errs++;
      $display("FAIL collide_qa_old got %h want 00000000", qa_a);
    end
    w_a = 1'b0;
    tick();
    vecs++;
    if (qb_a !== 32'h0000_FFFF || qb_b !== 32'h0000_FFFF) begin
      errs++;
      $display("FAIL collide_after got %h/%h want 0000ffff", qb_a, qb_b);
    end
    // Different addresses: bypass must not kick in.
    w_a = 1'b1; a_a = 8'h21; be_a = 4'hF; d_a = 32'h5555_5555; a_b = 8'h10;
    tick();
    vecs++;
    if (qb_a !== 32'hCAFE_F00D || qb_b !== 32'hCAFE_F00D) begin
      errs++;
      $display("FAIL no_collide got %h/%h want cafef00d", qb_a, qb_b);
    end
    idle();
  endtask

  task automatic test_hold();
    ena_a = 1'b1; a_a = 8'h10; ena_b = 1'b1; a_b = 8'h05;
    tick();
    vecs++;
    if (qa_a !== 32'hCAFE_F00D || qb_a !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL hold_setup got %h/%h want cafef00d/aa22cc44", qa_a, qb_a);
    end
    ena_a = 1'b0; w_a = 1'b1; a_a = 8'h30; be_a = 4'hF; d_a = 32'hDEAD_BEEF;
    ena_b = 1'b0; a_b = 8'h20;
    tick();
    vecs++;
    if (qa_a !== 32'hCAFE_F00D) begin
      errs++;
      $display("FAIL hold_qa got %h want cafef00d", qa_a);
    end
    vecs++;
    if (qb_a !== 32'hAA22_CC44 || qb_b !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL hold_qb got %h/%h want aa22cc44", qb_a, qb_b);
    end
    ena_a = 1'b1; w_a = 1'b0;
    tick();
    vecs++;
    if (qa_a !== 32'h0) begin
      errs++;
      $display("FAIL hold_nowrite got %h want 00000000", qa_a);
    end
    // Zero byte enables: read happens, nothing written.
    w_a = 1'b1; a_a = 8'h05; be_a = 4'h0; d_a = 32'hFFFF_FFFF;
    tick();
    vecs++;
    if (qa_a !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL be_zero_read got %h want aa22cc44", qa_a);
    end
    w_a = 1'b0;
    tick();
    vecs++;
    if (qa_a !== 32'hAA22_CC44) begin
      errs++;
      $display("FAIL be_zero_keep got %h want aa22cc44", qa_a);
    end
    idle();
  endtask

  task automatic test_reset_mid_sweep();
    int ks, kb;
    nres = 1'b0;
    #2;
    vecs++;
    if (qa_a !== 32'h0 || qb_a !== 32'h0 || qa_n !== 32'h0) begin
      errs++;
      $display("FAIL async_reset_q got %h/%h/%h want 0", qa_a, qb_a, qa_n);
    end
    vecs++;
    if (busy_s !== 1'b1) begin
      errs++;
      $display("FAIL async_reset_busy got %b want 1", busy_s);
    end
    tick();
    nres = 1'b1;
    repeat (7) tick();
    vecs++;
    if (busy_s !== 1'b1) begin
      errs++;
      $display("FAIL mid_sweep_busy got %b want 1", busy_s);
    end
    nres = 1'b0;
    tick();
    nres = 1'b1;
    sweep_len(1'b1, ks, kb);
    vecs++;
    if (ks != 16) begin
      errs++;
      $display("FAIL restart_len_small got %0d want 16", ks);
    end
    vecs++;
    if (kb != 256) begin
      errs++;
      $display("FAIL restart_len_big got %0d want 256", kb);
    end
    ena_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_a = 8'(i);
      tick();
      vecs++;
      if (qa_s !== 32'h0) begin
        errs++;
        $display("FAIL restart_read_small[%0d] got %h want 00000000", i, qa_s);
      end
    end
    a_a = 8'h05;
    tick();
    vecs++;
    if (qa_a !== 32'h0) begin
      errs++;
      $display("FAIL restart_read_big got %h want 00000000", qa_a);
    end
    // No sweep on u_n: the writes issued right after release landed.
    a_a = 8'h03;
    tick();
    vecs++;
    if (qa_n !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL noclear_write got %h want ffffffff", qa_n);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sweep();
    test_byte_enable();
    test_read_first();
    test_collision();
    test_hold();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
